// File: rtl/irq_pending_encoder.sv
// irq_pending_encoder
// Sticky request collector in front of a fixed-priority encoder. Request events are latched
// into a pending register; the highest-index pending bit is granted as a registered index plus
// valid and held until the consumer acks. Only the acked bit is cleared, so simultaneous and
// back-to-back requests are never lost.
//
// Parameters:
//   WIDTH : number of request lines (power of two, 2..16)
//   EDGE  : 1 = capture rising edges of req, 0 = capture while req is high
//
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   req     : request lines, synchronous to clk
//   mask    : per-line grant enable, 1 = enabled (only with IRQ_MASK_EN)
//   ack     : consumer accepts idx; only honoured while a grant is held
//   valid   : idx holds a granted request
//   idx     : index of the granted request, MSB has highest priority
//   pending : current sticky pending register (status)
//
// Optional build macro IRQ_MASK_EN adds the mask input. Masked bits still latch into pending
// and are granted once unmasked.

module irq_pending_encoder #(
  parameter int unsigned WIDTH = 4,
  parameter bit          EDGE  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
`ifdef IRQ_MASK_EN
  input  logic [WIDTH-1:0]         mask,
`endif
  input  logic                     ack,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic [WIDTH-1:0]         pending
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [WIDTH-1:0]   req_prev_q;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [WIDTH-1:0]   set_vec;
  logic [WIDTH-1:0]   clr_vec;
  logic [WIDTH-1:0]   eligible;
  logic [IDX_W-1:0]   sel;

`ifdef IRQ_MASK_EN
  assign eligible = pend_q & mask;
`else
  assign eligible = pend_q;
`endif

  // Capture and pending update. OR-ing set_vec last lets a new event on the acked bit survive.
  always_comb begin
    if (EDGE) begin
      set_vec = req & ~req_prev_q;
    end else begin
      set_vec = req;
    end
    clr_vec = '0;
    if ((state_q == StGrant) && ack) begin
      clr_vec[idx_q] = 1'b1;
    end
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  // Fixed priority: later (higher) indices overwrite earlier ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (eligible[i]) begin
        sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        // ack is meaningless here; idx keeps its last value while nothing is eligible.
        if (|eligible) begin
          idx_d   = sel;
          valid_d = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // No preemption: the held grant only ends on ack.
        if (ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      req_prev_q <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_prev_q <= req;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
    end
  end

  assign valid   = valid_q;
  assign idx     = idx_q;
  assign pending = pend_q;

endmodule
